// File: rtl/csa_pkg.sv
// Shared constants and types for the 64-bit carry-select adder.
package csa_pkg;
  localparam int WIDTH   = 64;
  localparam int GROUP_W = 8;
  localparam int NGROUPS = WIDTH / GROUP_W;

  typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/rca_group.sv
// Ripple-carry adder slice built from explicit full adders; used as one
// carry-select group (or both halves of a precomputed pair).
module rca_group #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] w_c;

  assign w_c[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign s[gi]       = a[gi] ^ b[gi] ^ w_c[gi];
    assign w_c[gi + 1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = w_c[W];
endmodule

// File: rtl/csa64_eqg.sv
// 64-bit unsigned carry-select adder with equal-size groups, registered
// operands and registered {crout,sum}: two-edge latency, one pair per cycle.
module csa64_eqg #(
  parameter int GROUP_W = csa_pkg::GROUP_W
) (
  output csa_pkg::word_t sum,
  output logic           crout,
  input  csa_pkg::word_t op1,
  input  csa_pkg::word_t op2,
  input  logic           clock,
  input  logic           reset
);
  import csa_pkg::*;

  localparam int NGROUPS = WIDTH / GROUP_W;

  word_t            r_op1_q;
  word_t            r_op2_q;
  word_t            w_sum_sel;
  logic [NGROUPS:1] w_gc;   // w_gc[g] is the carry into group g

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_grp
    if (gi == 0) begin : g_ripple
      rca_group #(.W(GROUP_W)) u_rca (
        .a   (r_op1_q[0 +: GROUP_W]),
        .b   (r_op2_q[0 +: GROUP_W]),
        .cin (1'b0),
        .s   (w_sum_sel[0 +: GROUP_W]),
        .cout(w_gc[1])
      );
    end else begin : g_select
      logic [GROUP_W-1:0] w_s0;
      logic [GROUP_W-1:0] w_s1;
      logic               w_c0;
      logic               w_c1;

      rca_group #(.W(GROUP_W)) u_rca0 (
        .a   (r_op1_q[gi*GROUP_W +: GROUP_W]),
        .b   (r_op2_q[gi*GROUP_W +: GROUP_W]),
        .cin (1'b0),
        .s   (w_s0),
        .cout(w_c0)
      );

      rca_group #(.W(GROUP_W)) u_rca1 (
        .a   (r_op1_q[gi*GROUP_W +: GROUP_W]),
        .b   (r_op2_q[gi*GROUP_W +: GROUP_W]),
        .cin (1'b1),
        .s   (w_s1),
        .cout(w_c1)
      );

      assign w_sum_sel[gi*GROUP_W +: GROUP_W] = w_gc[gi] ? w_s1 : w_s0;
      assign w_gc[gi + 1]                     = w_gc[gi] ? w_c1 : w_c0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op1_q <= '0;
      r_op2_q <= '0;
      sum     <= '0;
      crout   <= 1'b0;
    end else begin
      r_op1_q <= op1;
      r_op2_q <= op2;
      sum     <= w_sum_sel;
      crout   <= w_gc[NGROUPS];
    end
  end
endmodule

// File: tb/tb_csa64_eqg.sv
// Randomised and directed bench for csa64_eqg against a plain 65-bit
// addition model with a two-edge result queue.
module tb_csa64_eqg;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] op1   = '0;
  logic [63:0] op2   = '0;
  logic [63:0] sum;
  logic        crout;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Expected {crout,sum} values in issue order; front is the one due next.
  logic [64:0] exp_q[$];

  csa64_eqg dut (
    .sum  (sum),
    .crout(crout),
    .op1  (op1),
    .op2  (op2),
    .clock(clock),
    .reset(reset)
  );

  always #3 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one pair for the next edge, then compare the result that edge exposes.
  task automatic apply(input logic [63:0] a, input logic [63:0] b, input string tag);
    logic [64:0] e;
    op1 = a;
    op2 = b;
    exp_q.push_back({1'b0, a} + {1'b0, b});
    @(posedge clock);
    #1;
    n_txn++;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      $display("txn %0d %s: op1=%h op2=%h out=%h exp=%h", n_txn, tag, a, b, {crout, sum}, e);
      check(tag, {crout, sum}, e);
    end
  endtask

  // Registered operands come out of reset as zero, so the first result is 0+0.
  task automatic restart_model();
    exp_q.delete();
    exp_q.push_back(65'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;

    reset = 1'b1;
    #1;
    check("reset_state", {crout, sum}, 65'd0);
    reset = 1'b0;
    restart_model();

    apply(64'd0, 64'd0, "t1_zero_a");
    apply(64'd0, 64'd0, "t1_zero_b");
    check("t1_const", {crout, sum}, 65'd0);

    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_DDDD_CCCC_FFFF, "t2_op");
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, "t3_op");
    check("t2_const", {crout, sum}, {1'b1, 64'hEEEE_DDDD_CCCC_FFFE});
    apply(64'h0000_0000_0000_00FF, 64'h1, "t4_op");
    check("t3_const", {crout, sum}, {1'b1, 64'h0});
    apply(64'd1, 64'd2, "t5_a");
    check("t4_const", {crout, sum}, {1'b0, 64'h0000_0000_0000_0100});
    apply(64'd3, 64'd4, "t5_b");
    check("t5_const_a", {crout, sum}, 65'd3);
    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "t5_c");
    check("t5_const_b", {crout, sum}, 65'd7);
    apply(64'd10, 64'd20, "t6_pre");
    check("t5_const_c", {crout, sum}, {1'b1, 64'h0});

    // Reset between edges with (10,20) and earlier results in flight.
    apply(64'd11, 64'd22, "t6_inflight");
    reset = 1'b1;
    op1   = 64'hDEAD_BEEF_0000_0001;
    op2   = 64'hFFFF_0000_FFFF_0000;
    #1;
    check("t6_async_clear", {crout, sum}, 65'd0);
    @(posedge clock);
    #1;
    check("t6_held", {crout, sum}, 65'd0);
    @(negedge clock);
    reset = 1'b0;
    restart_model();
    apply(64'd5, 64'd6, "t6_first");
    apply(64'd7, 64'd8, "t6_second");
    check("t6_const", {crout, sum}, 65'd11);

    // Random sweep with every fourth pair steered toward long carry chains.
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case (i % 4)
        1: rb = ~ra;
        2: rb = ~ra + 64'd1;
        3: rb = ~ra ^ (64'd1 << $urandom_range(63, 0));
        default: ;
      endcase
      apply(ra, rb, "rand");
    end
    apply(64'd0, 64'd0, "drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
